// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the MIX output-device side, the character FIFO
// and the UART transmitter's load/in/ready port.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic          wr;
  logic [6:0]    din;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tx_ready;
  logic          tx_load;
  logic [6:0]    tx_data;

  // Driven by the CPU-side writer and the transmitter.
  modport master (
    output wr, din, tx_ready,
    input  full, empty, count, overflow, tx_load, tx_data
  );

  // Driven by the FIFO.
  modport slave (
    input  wr, din, tx_ready,
    output full, empty, count, overflow, tx_load, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// DEPTH-entry character buffer feeding the UART transmitter one frame at a time.
// Define UART_TX_FIFO_CRLF_EN to expand LF into CR LF on the wire.
//   state   | meaning (UART_TX_FIFO_CRLF_EN only)
//   HEAD    | head sent as stored; an LF head is first sent as CR
//   CR_SENT | CR already sent for the LF head; send the LF and pop it
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_fifo_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [6:0]  CH_LF    = 7'h0A;
  localparam logic [6:0]  CH_CR    = 7'h0D;

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic          ovf_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          accept;
  logic          pop;
  logic [6:0]    head;
  logic [6:0]    tx_data_c;

  // full is taken from registered state, so a same-cycle pop cannot admit a write.
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign push   = bus.wr & ~full;
  assign head   = mem[rd_ptr];
  assign accept = ~empty & bus.tx_ready;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.tx_load  = ~empty;
  assign bus.tx_data  = tx_data_c;

`ifdef UART_TX_FIFO_CRLF_EN
  typedef enum logic {
    HEAD    = 1'b0,
    CR_SENT = 1'b1
  } crlf_state_t;

  crlf_state_t state_q;
  crlf_state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HEAD;
    end else begin
      state_q <= state_d;
    end
  end

  // An LF head is accepted twice: first as CR (kept), then as LF (popped).
  always_comb begin
    state_d   = state_q;
    tx_data_c = head;
    pop       = accept;
    case (state_q)
      HEAD: begin
        if (head == CH_LF) begin
          tx_data_c = CH_CR;
          pop       = 1'b0;
          if (accept) state_d = CR_SENT;
        end
      end
      CR_SENT: begin
        if (accept) state_d = HEAD;
      end
      default: state_d = HEAD;
    endcase
  end
`else
  assign tx_data_c = head;
  assign pop       = accept;
`endif

  // Storage is intentionally not reset; tx_data is ignored while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (bus.wr && full) ovf_q <= 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
